// File: rtl/pipe_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage MIPS core: merges hazard, memory and MDU stalls, with a bus watchdog.
// Optional stall performance counter enabled by defining PIPE_STALL_PERF_CNT_EN.
`timescale 1ns/1ps
module pipe_stall_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int WAIT_W  = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             haz_stall,
  input  logic             haz_flushd,
  input  logic             imem_req,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             mdu_start,
  input  logic             mdu_done,
  output logic             stallf,
  output logic             stalld,
  output logic             stalle,
  output logic             stallm,
  output logic             stallw,
  output logic             flushd,
  output logic             flushe,
  output logic             flushm,
  output logic [1:0]       state,
  output logic             timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    MDU_BUSY = 2'b10,
    HALT     = 2'b11
  } state_t;

  state_t            cur_state, next_state;
  logic [WAIT_W-1:0] wait_cnt, next_wait;
  logic              mdu_pend;
  logic              mem_miss;
  logic              freeze;

  assign mem_miss = (imem_req & ~imem_ready) | (dmem_req & ~dmem_ready);
  assign freeze   = mem_miss | (cur_state == MEM_WAIT) | (cur_state == HALT);
  assign state    = cur_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= RUN;
      wait_cnt  <= '0;
      mdu_pend  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      cur_state <= next_state;
      wait_cnt  <= next_wait;
      // Clear wins over set when an operation issues and completes together.
      if (mdu_done)
        mdu_pend <= 1'b0;
      else if (mdu_start && !freeze && cur_state == RUN)
        mdu_pend <= 1'b1;
      if (next_state == HALT)
        timeout <= 1'b1;
    end
  end

  always_comb begin
    next_state = cur_state;
    next_wait  = wait_cnt;
    case (cur_state)
      RUN: begin
        if (mem_miss) begin
          next_state = MEM_WAIT;
          next_wait  = WAIT_W'(1);
        end else if (mdu_start && !mdu_done) begin
          next_state = MDU_BUSY;
        end
      end
      MEM_WAIT: begin
        // The >= compare also covers TIMEOUT=1, where the entry count already exceeds the limit.
        if (mem_miss) begin
          if (wait_cnt >= WAIT_W'(TIMEOUT - 1))
            next_state = HALT;
          else
            next_wait = wait_cnt + WAIT_W'(1);
        end else begin
          next_wait  = '0;
          next_state = (mdu_pend && !mdu_done) ? MDU_BUSY : RUN;
        end
      end
      MDU_BUSY: begin
        if (mem_miss) begin
          next_state = MEM_WAIT;
          next_wait  = WAIT_W'(1);
        end else if (mdu_done) begin
          next_state = RUN;
        end
      end
      default: next_state = HALT;
    endcase
  end

  always_comb begin
    stallf = 1'b0;
    stalld = 1'b0;
    stalle = 1'b0;
    stallm = 1'b0;
    stallw = 1'b0;
    flushd = 1'b0;
    flushe = 1'b0;
    flushm = 1'b0;
    if (freeze) begin
      stallf = 1'b1;
      stalld = 1'b1;
      stalle = 1'b1;
      stallm = 1'b1;
      stallw = 1'b1;
    end else if (cur_state == MDU_BUSY) begin
      stallf = 1'b1;
      stalld = 1'b1;
      stalle = 1'b1;
      flushm = 1'b1;
    end else begin
      stallf = haz_stall;
      stalld = haz_stall;
      flushe = haz_stall;
      flushd = haz_flushd & ~haz_stall;
    end
  end

`ifdef PIPE_STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (stallf && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + CNT_W'(1);
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed vectors push expectations, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_pipe_stall_ctrl;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [7:0] HS   = 8'h80;
  localparam logic [7:0] HF   = 8'h40;
  localparam logic [7:0] IR   = 8'h20;
  localparam logic [7:0] IRDY = 8'h10;
  localparam logic [7:0] DR   = 8'h08;
  localparam logic [7:0] DRDY = 8'h04;
  localparam logic [7:0] MS   = 8'h02;
  localparam logic [7:0] MD   = 8'h01;
  localparam logic [7:0] NOIN = 8'h00;

  localparam logic [4:0] S_ALL  = 5'b11111;
  localparam logic [4:0] S_MDU  = 5'b11100;
  localparam logic [4:0] S_HAZ  = 5'b11000;
  localparam logic [4:0] S_NONE = 5'b00000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic haz_stall = 1'b0, haz_flushd = 1'b0;
  logic imem_req = 1'b0, imem_ready = 1'b0;
  logic dmem_req = 1'b0, dmem_ready = 1'b0;
  logic mdu_start = 1'b0, mdu_done = 1'b0;
  logic stallf, stalld, stalle, stallm, stallw;
  logic flushd, flushe, flushm;
  logic [1:0] state;
  logic timeout;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct {
    string            tag;
    logic [4:0]       stl;
    logic [2:0]       fl;
    logic [1:0]       st;
    logic             tmo;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int failures = 0;
  int modelCnt = 0;

  pipe_stall_ctrl #(.TIMEOUT(4), .WAIT_W(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .haz_stall(haz_stall), .haz_flushd(haz_flushd),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .mdu_start(mdu_start), .mdu_done(mdu_done),
    .stallf(stallf), .stalld(stalld), .stalle(stalle), .stallm(stallm), .stallw(stallw),
    .flushd(flushd), .flushe(flushe), .flushm(flushm),
    .state(state), .timeout(timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue what that cycle must show.
  task automatic applyStimulus(input string tag, input logic rst, input logic [7:0] in,
                               input logic [4:0] expStl, input logic [2:0] expFl,
                               input logic [1:0] expSt, input logic expTmo);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = ~rst;
    {haz_stall, haz_flushd, imem_req, imem_ready, dmem_req, dmem_ready, mdu_start, mdu_done} = in;
    if (rst) modelCnt = 0;
    e.tag = tag;
    e.stl = expStl;
    e.fl  = expFl;
    e.st  = expSt;
    e.tmo = expTmo;
    e.cnt = CNT_W'(modelCnt);
    expQ.push_back(e);
`ifdef PIPE_STALL_PERF_CNT_EN
    if (!rst && expStl[4] && modelCnt < CNT_MAX) modelCnt = modelCnt + 1;
`endif
  endtask

  task automatic checkOutput(input exp_t e);
    logic [4:0] gotStl;
    logic [2:0] gotFl;
    gotStl = {stallf, stalld, stalle, stallm, stallw};
    gotFl  = {flushd, flushe, flushm};
    checks++;
    if (gotStl !== e.stl || gotFl !== e.fl || state !== e.st || timeout !== e.tmo || stall_cnt !== e.cnt) begin
      failures++;
      $display("[TB] FAIL %s: got stl=%b fl=%b st=%b tmo=%b cnt=%0d, expected stl=%b fl=%b st=%b tmo=%b cnt=%0d",
               e.tag, gotStl, gotFl, state, timeout, stall_cnt, e.stl, e.fl, e.st, e.tmo, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] bench time limit expired");
  end

  initial begin
    applyStimulus("reset0", 1'b1, NOIN, S_NONE, 3'b000, 2'b00, 1'b0);
    applyStimulus("reset1", 1'b1, NOIN, S_NONE, 3'b000, 2'b00, 1'b0);
    applyStimulus("idle", 1'b0, NOIN, S_NONE, 3'b000, 2'b00, 1'b0);

    // Hazard passthrough
    applyStimulus("haz_stall", 1'b0, HS, S_HAZ, 3'b010, 2'b00, 1'b0);
    applyStimulus("haz_both", 1'b0, HS | HF, S_HAZ, 3'b010, 2'b00, 1'b0);
    applyStimulus("haz_flushd", 1'b0, HF, S_NONE, 3'b100, 2'b00, 1'b0);

    // Data miss for three cycles, then ready
    applyStimulus("dmiss_c0", 1'b0, DR, S_ALL, 3'b000, 2'b00, 1'b0);
    applyStimulus("dmiss_c1", 1'b0, DR, S_ALL, 3'b000, 2'b01, 1'b0);
    applyStimulus("dmiss_c2", 1'b0, DR, S_ALL, 3'b000, 2'b01, 1'b0);
    applyStimulus("dmiss_ready", 1'b0, DR | DRDY, S_ALL, 3'b000, 2'b01, 1'b0);
    applyStimulus("dmiss_after", 1'b0, NOIN, S_NONE, 3'b000, 2'b00, 1'b0);

    // MDU sequencing, hazard inputs ignored while busy
    applyStimulus("mdu_start", 1'b0, MS, S_NONE, 3'b000, 2'b00, 1'b0);
    applyStimulus("mdu_b1", 1'b0, NOIN, S_MDU, 3'b001, 2'b10, 1'b0);
    applyStimulus("mdu_b2_haz", 1'b0, HS | HF, S_MDU, 3'b001, 2'b10, 1'b0);
    applyStimulus("mdu_b3", 1'b0, NOIN, S_MDU, 3'b001, 2'b10, 1'b0);
    applyStimulus("mdu_b4", 1'b0, NOIN, S_MDU, 3'b001, 2'b10, 1'b0);
    applyStimulus("mdu_done", 1'b0, MD, S_MDU, 3'b001, 2'b10, 1'b0);
    applyStimulus("mdu_after", 1'b0, NOIN, S_NONE, 3'b000, 2'b00, 1'b0);

    // Overlap: MDU finishes during an imem miss, exit to RUN
    applyStimulus("ovA_start", 1'b0, MS, S_NONE, 3'b000, 2'b00, 1'b0);
    applyStimulus("ovA_busy", 1'b0, NOIN, S_MDU, 3'b001, 2'b10, 1'b0);
    applyStimulus("ovA_miss", 1'b0, IR, S_ALL, 3'b000, 2'b10, 1'b0);
    applyStimulus("ovA_done_in_wait", 1'b0, IR | MD, S_ALL, 3'b000, 2'b01, 1'b0);
    applyStimulus("ovA_ready", 1'b0, IR | IRDY, S_ALL, 3'b000, 2'b01, 1'b0);
    applyStimulus("ovA_run", 1'b0, NOIN, S_NONE, 3'b000, 2'b00, 1'b0);

    // Overlap: MDU still pending when the miss clears, exit to MDU_BUSY
    applyStimulus("ovB_start", 1'b0, MS, S_NONE, 3'b000, 2'b00, 1'b0);
    applyStimulus("ovB_busy", 1'b0, NOIN, S_MDU, 3'b001, 2'b10, 1'b0);
    applyStimulus("ovB_miss", 1'b0, IR, S_ALL, 3'b000, 2'b10, 1'b0);
    applyStimulus("ovB_ready", 1'b0, IR | IRDY, S_ALL, 3'b000, 2'b01, 1'b0);
    applyStimulus("ovB_back_busy", 1'b0, NOIN, S_MDU, 3'b001, 2'b10, 1'b0);
    applyStimulus("ovB_done", 1'b0, MD, S_MDU, 3'b001, 2'b10, 1'b0);
    applyStimulus("ovB_run", 1'b0, NOIN, S_NONE, 3'b000, 2'b00, 1'b0);

    // Watchdog with TIMEOUT=4
    applyStimulus("wd_c0", 1'b0, IR, S_ALL, 3'b000, 2'b00, 1'b0);
    applyStimulus("wd_c1", 1'b0, IR, S_ALL, 3'b000, 2'b01, 1'b0);
    applyStimulus("wd_c2", 1'b0, IR, S_ALL, 3'b000, 2'b01, 1'b0);
    applyStimulus("wd_c3", 1'b0, IR, S_ALL, 3'b000, 2'b01, 1'b0);
    applyStimulus("wd_halt_ready", 1'b0, IR | IRDY, S_ALL, 3'b000, 2'b11, 1'b1);
    applyStimulus("wd_halt_idle", 1'b0, NOIN, S_ALL, 3'b000, 2'b11, 1'b1);
    applyStimulus("wd_reset", 1'b1, NOIN, S_NONE, 3'b000, 2'b00, 1'b0);
    applyStimulus("wd_after_reset", 1'b0, NOIN, S_NONE, 3'b000, 2'b00, 1'b0);
    applyStimulus("post_haz", 1'b0, HS, S_HAZ, 3'b010, 2'b00, 1'b0);
    applyStimulus("post_cnt", 1'b0, NOIN, S_NONE, 3'b000, 2'b00, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
